// File: rtl/logic_unit_arbiter_pkg.sv
// logic_unit_arbiter_pkg
//   Shared definitions for the two-requester bitwise logic unit arbiter:
//   opcode encodings and the controller state encoding.
package logic_unit_arbiter_pkg;

    localparam int OPW_DEFAULT = 2;

    // Opcode encodings for the shared bitwise unit.
    localparam logic [1:0] OP_AND = 2'b00;  // a & b
    localparam logic [1:0] OP_OR  = 2'b01;  // a | b
    localparam logic [1:0] OP_XOR = 2'b10;  // a ^ b
    localparam logic [1:0] OP_NOR = 2'b11;  // ~(a | b)

    // IDLE accepts a new operation; HOLD presents a result until its owner takes it.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/logic_unit_arbiter_rr_arbiter_2.sv
// rr_arbiter_2
//   Two-requester round-robin grant logic, purely combinational.
//   When both requesters are valid, the one named by prio wins; a lone
//   requester always wins. No grant is issued while enable is low.
// Ports:
//   valid0, valid1 : request valid from requester 0 / 1
//   prio           : requester favoured when both are valid
//   enable         : arbitration allowed this cycle
//   grant[1:0]     : one-hot grant (or all zero)
module rr_arbiter_2 (
    input  logic       valid0,
    input  logic       valid1,
    input  logic       prio,
    input  logic       enable,
    output logic [1:0] grant
);

    always_comb begin
        grant[0] = enable & valid0 & (~valid1 | ~prio);
        grant[1] = enable & valid1 & (~valid0 |  prio);
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter
//   Shares one WIDTH-bit bitwise logic unit (AND/OR/XOR/NOR) between two
//   requesters. An accepted operation is computed combinationally and
//   captured into a single result register, which is held until the owning
//   requester accepts it. At most one operation every two cycles.
// Ports:
//   clock, reset               : rising-edge clock, synchronous active-high reset
//   reqN_valid/ready/op/a/b    : request handshake and operands, N = 0, 1
//   respN_valid/ready          : response handshake, N = 0, 1
//   resp_data                  : shared registered result
//   busy                       : high while a result is held (HOLD)
module logic_unit_arbiter
    import logic_unit_arbiter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OPW   = OPW_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OPW-1:0]   req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OPW-1:0]   req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             busy
);

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic             prio_q, prio_d;
    logic [WIDTH-1:0] data_q, data_d;

    logic [1:0]       grant;
    logic [OPW-1:0]   sel_op;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic [WIDTH-1:0] and_res, or_res, xor_res, result;

    rr_arbiter_2 u_arb (
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .prio   (prio_q),
        .enable (state_q == ST_IDLE),
        .grant  (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    // Operand select from the granted requester; the unit itself is shared.
    always_comb begin
        sel_op = grant[1] ? req1_op : req0_op;
        sel_a  = grant[1] ? req1_a  : req0_a;
        sel_b  = grant[1] ? req1_b  : req0_b;
    end

    // Bitwise unit: NOR reuses the OR output inverted.
    assign and_res = sel_a & sel_b;
    assign or_res  = sel_a | sel_b;
    assign xor_res = sel_a ^ sel_b;

    always_comb begin
        unique case (sel_op[1:0])
            OP_AND:  result = and_res;
            OP_OR:   result = or_res;
            OP_XOR:  result = xor_res;
            default: result = ~or_res;
        endcase
    end

    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        prio_d  = prio_q;
        data_d  = data_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|grant) begin
                    state_d = ST_HOLD;
                    owner_d = grant[1];
                    prio_d  = ~grant[1];
                    data_d  = result;
                end
            end
            ST_HOLD: begin
                // Only the owner's ready releases the result.
                if (owner_q ? resp1_ready : resp0_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
            data_q  <= data_d;
        end
    end

    assign busy        = (state_q == ST_HOLD);
    assign resp0_valid = busy & ~owner_q;
    assign resp1_valid = busy &  owner_q;
    assign resp_data   = data_q;

endmodule
